// File: rtl/pc_tx_arbiter.sv
// Two-requester round-robin arbiter framing messages into the PC_TX write port.
// Each message gets a header word; a mid-message stall beyond TIMEOUT_CYCLES is closed with an abort word.
module pc_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [23:0] HDR_TAG        = 24'hA5A55A
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_req0_data,
  input  logic        i_req0_valid,
  input  logic        i_req0_last,
  output logic        o_req0_ready,
  input  logic [31:0] i_req1_data,
  input  logic        i_req1_valid,
  input  logic        i_req1_last,
  output logic        o_req1_ready,
  output logic [31:0] o_fifo_write_word_data,
  output logic        o_fifo_write_word_cmd,
  input  logic        i_fifo_full,
  output logic [1:0]  o_grant,
  output logic        o_abort
);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, ABORT} state_t;

  localparam logic [15:0] STALL_MAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_src_q, last_src_d;
  logic [15:0] stall_q, stall_d;

  logic        src;
  logic        g_valid;
  logic        g_last;
  logic [31:0] g_data;

  assign src     = grant_q[1];
  assign o_grant = grant_q;

  always_comb begin
    g_valid = src ? i_req1_valid : i_req0_valid;
    g_last  = src ? i_req1_last  : i_req0_last;
    g_data  = src ? i_req1_data  : i_req0_data;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_src_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_src_q <= last_src_d;
      stall_q    <= stall_d;
    end
  end

  // Stall counter defaults to clear; only a continuing STREAM cycle keeps or advances it.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_src_d = last_src_q;
    stall_d    = '0;
    case (state_q)
      IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          state_d = HEADER;
          if (i_req0_valid && i_req1_valid)
            grant_d = last_src_q ? 2'b01 : 2'b10;
          else
            grant_d = i_req0_valid ? 2'b01 : 2'b10;
        end
      end
      HEADER: begin
        if (!i_fifo_full) state_d = STREAM;
      end
      STREAM: begin
        if (i_fifo_full) begin
          stall_d = stall_q;
        end else if (g_valid) begin
          if (g_last) begin
            state_d    = IDLE;
            grant_d    = '0;
            last_src_d = src;
          end
        end else if (stall_q == STALL_MAX) begin
          state_d = ABORT;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      ABORT: begin
        if (!i_fifo_full) begin
          state_d    = IDLE;
          grant_d    = '0;
          last_src_d = src;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready           = 1'b0;
    o_req1_ready           = 1'b0;
    o_fifo_write_word_cmd  = 1'b0;
    o_fifo_write_word_data = '0;
    o_abort                = 1'b0;
    case (state_q)
      HEADER: begin
        o_fifo_write_word_cmd  = !i_fifo_full;
        o_fifo_write_word_data = {HDR_TAG, 7'b0, src};
      end
      STREAM: begin
        o_req0_ready           = grant_q[0] && !i_fifo_full;
        o_req1_ready           = grant_q[1] && !i_fifo_full;
        o_fifo_write_word_cmd  = g_valid && !i_fifo_full;
        o_fifo_write_word_data = g_data;
      end
      ABORT: begin
        o_fifo_write_word_cmd  = !i_fifo_full;
        o_fifo_write_word_data = {HDR_TAG, 7'h7F, 1'b1};
        o_abort                = !i_fifo_full;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_tx_arbiter.sv
// Bench for pc_tx_arbiter: directed vector table, an alternation sequence, and a
// randomized run checked against a message-level reference model.
module tb_pc_tx_arbiter;

  localparam int          TO  = 4;
  localparam logic [23:0] TAG = 24'hA5A55A;
  localparam logic [31:0] H0  = 32'hA5A55A00;
  localparam logic [31:0] H1  = 32'hA5A55A01;
  localparam logic [31:0] AB  = 32'hA5A55AFF;

  logic        clk = 1'b0;
  logic        rst_n, v0, l0, v1, l1, full;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, cmd, abrt;
  logic [31:0] wdata;
  logic [1:0]  grant;
  logic [37:0] dut_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_tx_arbiter #(.TIMEOUT_CYCLES(TO), .HDR_TAG(TAG)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0_data(d0), .i_req0_valid(v0), .i_req0_last(l0), .o_req0_ready(rdy0),
    .i_req1_data(d1), .i_req1_valid(v1), .i_req1_last(l1), .o_req1_ready(rdy1),
    .o_fifo_write_word_data(wdata), .o_fifo_write_word_cmd(cmd),
    .i_fifo_full(full), .o_grant(grant), .o_abort(abrt)
  );

  assign dut_out = {cmd, wdata, grant, rdy0, rdy1, abrt};

  // ---------------- reference model (message level) ----------------
  typedef enum {M_IDLE, M_HDR, M_DATA, M_ABT} mph_t;
  mph_t m_ph   = M_IDLE;
  int   m_own  = -1;
  int   m_prev = 1;
  int   m_stall = 0;

  function automatic logic [37:0] model_out();
    logic c, r0, r1, a;
    logic [31:0] d;
    logic [1:0] g;
    c = 1'b0; r0 = 1'b0; r1 = 1'b0; a = 1'b0; d = '0;
    g = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    case (m_ph)
      M_HDR:  begin c = !full; d = {TAG, 7'b0, (m_own == 1)}; end
      M_DATA: begin
        r0 = (m_own == 0) && !full;
        r1 = (m_own == 1) && !full;
        c  = ((m_own == 0) ? v0 : v1) && !full;
        d  = (m_own == 0) ? d0 : d1;
      end
      M_ABT:  begin c = !full; d = {TAG, 8'hFF}; a = !full; end
      default: ;
    endcase
    return {c, d, g, r0, r1, a};
  endfunction

  task automatic model_step();
    logic v, l;
    if (!rst_n) begin
      m_ph = M_IDLE; m_own = -1; m_prev = 1; m_stall = 0;
      return;
    end
    case (m_ph)
      M_IDLE: if (v0 || v1) begin
        m_own = (v0 && v1) ? 1 - m_prev : (v0 ? 0 : 1);
        m_ph  = M_HDR;
      end
      M_HDR: if (!full) m_ph = M_DATA;
      M_DATA: begin
        v = (m_own == 0) ? v0 : v1;
        l = (m_own == 0) ? l0 : l1;
        if (!full) begin
          if (v) begin
            m_stall = 0;
            if (l) begin m_prev = m_own; m_own = -1; m_ph = M_IDLE; end
          end else if (m_stall == TO - 1) begin
            m_stall = 0; m_ph = M_ABT;
          end else begin
            m_stall++;
          end
        end
      end
      M_ABT: if (!full) begin m_prev = m_own; m_own = -1; m_ph = M_IDLE; end
      default: ;
    endcase
  endtask

  // Inputs are set just after an edge; outputs are sampled 1ns later, well before the next edge.
  task automatic settle();
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got cmd=%b data=%h grant=%b rdy=%b%b abort=%b want cmd=%b data=%h grant=%b rdy=%b%b abort=%b",
               name, act[37], act[36:5], act[4:3], act[2], act[1], act[0],
               exp[37], exp[36:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic set_in(input logic r, input logic a0, input logic b0, input logic [31:0] c0,
                        input logic a1, input logic b1, input logic [31:0] c1, input logic f);
    rst_n = r; v0 = a0; l0 = b0; d0 = c0; v1 = a1; l1 = b1; d1 = c1; full = f;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) begin settle(); advance(); end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n, v0, l0, v1, l1, full, chk;
    logic [31:0] d0, d1;
    logic [37:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [37:0] ex(input logic c, input logic [31:0] d, input logic [1:0] g,
                                     input logic r0, input logic r1, input logic a);
    return {c, d, g, r0, r1, a};
  endfunction

  function automatic vec_t row(input logic r, input logic a0, input logic b0, input logic [31:0] c0,
                               input logic a1, input logic b1, input logic [31:0] c1,
                               input logic f, input logic k, input logic [37:0] e);
    vec_t x;
    x.rst_n = r; x.v0 = a0; x.l0 = b0; x.d0 = c0; x.v1 = a1; x.l1 = b1; x.d1 = c1;
    x.full = f; x.chk = k; x.exp = e;
    return x;
  endfunction

  logic [37:0] Z;
  logic [33:0] seen[$];
  logic [33:0] want[9];
  logic [31:0] k0, k1;
  logic        acc0, acc1;

  initial begin
    Z = '0;
    // three-word message from req0
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0, 1'b1, Z));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'h11, 1'b0,1'b0,32'h0, 1'b0, 1'b1, Z));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'h11, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b1, H0, 2'b01, 1'b0,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'h11, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b1, 32'h11, 2'b01, 1'b1,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'h22, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b1, 32'h22, 2'b01, 1'b1,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b1,1'b1,32'h33, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b1, 32'h33, 2'b01, 1'b1,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0, 1'b1, Z));
    // req1: header held by full, then full for 5 cycles mid-stream with valid low
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b0,32'hA1, 1'b0, 1'b1, Z));
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b0,32'hA1, 1'b1, 1'b1, ex(1'b0, H1, 2'b10, 1'b0,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b0,32'hA1, 1'b0, 1'b1, ex(1'b1, H1, 2'b10, 1'b0,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b0,32'hA1, 1'b0, 1'b1, ex(1'b1, 32'hA1, 2'b10, 1'b0,1'b1,1'b0)));
    for (int unsigned i = 0; i < 5; i++)
      vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b1, 1'b1, ex(1'b0, 32'h0, 2'b10, 1'b0,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b1,1'b0,32'hA2, 1'b0, 1'b1, ex(1'b1, 32'hA2, 2'b10, 1'b0,1'b1,1'b0)));
    // four stall cycles, then the abort word
    for (int unsigned i = 0; i < 4; i++)
      vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b0, 32'h0, 2'b10, 1'b0,1'b1,1'b0)));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'hB1, 1'b1,1'b0,32'hC1, 1'b0, 1'b1, ex(1'b1, AB, 2'b10, 1'b0,1'b0,1'b1)));
    // both valid after abort of req1: req0 wins, req1 stays blocked
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'hB1, 1'b1,1'b0,32'hC1, 1'b0, 1'b1, Z));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'hB1, 1'b1,1'b0,32'hC1, 1'b0, 1'b1, ex(1'b1, H0, 2'b01, 1'b0,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'hB1, 1'b1,1'b0,32'hC1, 1'b0, 1'b1, ex(1'b1, 32'hB1, 2'b01, 1'b1,1'b0,1'b0)));
    // reset mid-message, then a fresh single-word message
    vecs.push_back(row(1'b0, 1'b1,1'b0,32'hB2, 1'b0,1'b0,32'h0, 1'b0, 1'b0, Z));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'hB2, 1'b0,1'b0,32'h0, 1'b0, 1'b1, Z));
    vecs.push_back(row(1'b1, 1'b1,1'b0,32'hB2, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b1, H0, 2'b01, 1'b0,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b1,1'b1,32'hB2, 1'b0,1'b0,32'h0, 1'b0, 1'b1, ex(1'b1, 32'hB2, 2'b01, 1'b1,1'b0,1'b0)));
    vecs.push_back(row(1'b1, 1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0, 1'b0, 1'b1, Z));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].rst_n, vecs[i].v0, vecs[i].l0, vecs[i].d0,
             vecs[i].v1, vecs[i].l1, vecs[i].d1, vecs[i].full);
      settle();
      if (vecs[i].chk) check($sformatf("vec[%0d]", i), dut_out, vecs[i].exp);
      advance();
    end

    // ---------------- alternation: both always valid, 2-word messages ----------------
    want[0] = {2'b01, H0}; want[1] = {2'b01, 32'h100}; want[2] = {2'b01, 32'h101};
    want[3] = {2'b10, H1}; want[4] = {2'b10, 32'h200}; want[5] = {2'b10, 32'h201};
    want[6] = {2'b01, H0}; want[7] = {2'b01, 32'h102}; want[8] = {2'b01, 32'h103};
    do_reset();
    k0 = '0; k1 = '0;
    for (int unsigned c = 0; c < 12; c++) begin
      set_in(1'b1, 1'b1, k0[0], 32'h100 + k0, 1'b1, k1[0], 32'h200 + k1, 1'b0);
      settle();
      if (cmd) seen.push_back({grant, wdata});
      acc0 = rdy0; acc1 = rdy1;
      advance();
      if (acc0) k0 = k0 + 32'd1;
      if (acc1) k1 = k1 + 32'd1;
    end
    checks++;
    if (seen.size() != 9) begin
      errors++;
      $display("FAIL alt_count got %0d writes want 9", seen.size());
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= seen.size() || seen[i] !== want[i]) begin
        errors++;
        $display("FAIL alt[%0d] got %h want %h", i, (i < seen.size()) ? seen[i] : 34'h0, want[i]);
      end
    end

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    for (int unsigned c = 0; c < 10000; c++) begin
      set_in(($urandom_range(0, 399) != 0),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), $urandom,
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), $urandom,
             ($urandom_range(0, 4) == 0));
      settle();
      check($sformatf("rand[%0d]", c), dut_out, model_out());
      if (cmd && full) begin
        checks++;
        errors++;
        $display("FAIL rand_full[%0d] got strobe 1 while full want 0", c);
      end
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
